// File: rtl/seq_pkg.sv
// Shared constants for the sequence generator and checker.
// The expected word sequence and the checker state encoding live here.
package seq_pkg;

  localparam int DATA_W  = 8;
  localparam int SEQ_LEN = 8;

  localparam logic [DATA_W-1:0] SEQ_VALUES [SEQ_LEN] = '{
    8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D
  };

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a synchronous clear.
// A clear wins over a simultaneous increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Holds at all-ones instead of wrapping back to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sequence_checker.sv
// Tracks an upstream word stream against the fixed expected sequence,
// reporting lock state, completed passes and mismatches with counters.
module sequence_checker #(
  parameter int DATA_W  = seq_pkg::DATA_W,
  parameter int SEQ_LEN = seq_pkg::SEQ_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  input  logic              clr,
  output logic              locked,
  output logic              seq_done,
  output logic              mismatch,
  output logic [7:0]        pass_count,
  output logic [7:0]        err_count
);

  import seq_pkg::*;

  localparam int IDX_W = $clog2(SEQ_LEN);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_d, mis_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      idx_q    <= '0;
      seq_done <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      seq_done <= done_d;
      mismatch <= mis_d;
    end
  end

  // A wrong word that happens to be the first entry re-syncs immediately
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    if (en) begin
      case (state_q)
        HUNT: begin
          if (data == SEQ_VALUES[0]) begin
            state_d = LOCKED;
            idx_d   = IDX_W'(1);
          end
        end
        LOCKED: begin
          if (data == SEQ_VALUES[idx_q]) begin
            if (idx_q == IDX_W'(SEQ_LEN - 1)) begin
              idx_d  = '0;
              done_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            mis_d = 1'b1;
            if (data == SEQ_VALUES[0]) begin
              idx_d = IDX_W'(1);
            end else begin
              state_d = HUNT;
              idx_d   = '0;
            end
          end
        end
        default: begin
          state_d = HUNT;
          idx_d   = '0;
        end
      endcase
    end
  end

  assign locked = (state_q == LOCKED);

  // Counters step on the same edge that launches the matching pulse
  sat_counter #(.W(8)) u_pass_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (done_d),
    .count (pass_count)
  );

  sat_counter #(.W(8)) u_err_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (mis_d),
    .count (err_count)
  );

endmodule

// File: tb/tb_sequence_checker.sv
// Directed self-checking bench for sequence_checker: one task per scenario,
// expected values written out by hand from the sequence AF BC E2 78 FF E2 0B 8D.
module tb_sequence_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] data;
  logic       clr;
  logic       locked;
  logic       seq_done;
  logic       mismatch;
  logic [7:0] pass_count;
  logic [7:0] err_count;

  int errors = 0;
  int checks = 0;

  logic [7:0] seq_words [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};

  sequence_checker dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .data       (data),
    .clr        (clr),
    .locked     (locked),
    .seq_done   (seq_done),
    .mismatch   (mismatch),
    .pass_count (pass_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  // Both pulses at once can never be legal
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (seq_done === 1'b1 && mismatch === 1'b1) begin
        errors++;
        $display("[TB] FAIL pulse_exclusive: seq_done=%b mismatch=%b required not both 1", seq_done, mismatch);
      end
    end
  end

  task automatic drive(input logic e, input logic [7:0] d, input logic c);
    @(negedge clk);
    en   = e;
    data = d;
    clr  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    en   = 1'b0;
    data = 8'h00;
    clr  = 1'b0;
    #2;
    checks++;
    if ({locked, seq_done, mismatch} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b required 000", {locked, seq_done, mismatch});
    end
    checks++;
    if (pass_count !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_pass_count: got %h required 00", pass_count);
    end
    checks++;
    if (err_count !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_err_count: got %h required 00", err_count);
    end
    en   = 1'b1;
    data = 8'hAF;
    @(posedge clk);
    #1;
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold_locked: got %b required 0", locked);
    end
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single_pass();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, seq_words[i], 1'b0);
      checks++;
      if ({locked, seq_done, mismatch} !== {1'b1, (i == 7), 1'b0}) begin
        errors++;
        $display("[TB] FAIL single_pass_word%0d: got %b required %b", i,
                 {locked, seq_done, mismatch}, {1'b1, (i == 7), 1'b0});
      end
    end
    checks++;
    if (pass_count !== 8'h01) begin
      errors++;
      $display("[TB] FAIL single_pass_count: got %h required 01", pass_count);
    end
    checks++;
    if (err_count !== 8'h00) begin
      errors++;
      $display("[TB] FAIL single_err_count: got %h required 00", err_count);
    end
    drive(1'b0, 8'h00, 1'b0);
    checks++;
    if (seq_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_done_one_cycle: got %b required 0", seq_done);
    end
  endtask

  task automatic test_back_to_back();
    int first_done  = -1;
    int second_done = -1;
    int n_done      = 0;
    logic lock_ok   = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, seq_words[i % 8], 1'b0);
      if (locked !== 1'b1) lock_ok = 1'b0;
      if (seq_done === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = i;
        else second_done = i;
      end
    end
    checks++;
    if (lock_ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_locked: got dropped required always 1");
    end
    checks++;
    if (n_done != 2 || first_done != 7 || second_done != 15) begin
      errors++;
      $display("[TB] FAIL b2b_done_timing: got n=%0d at %0d,%0d required n=2 at 7,15",
               n_done, first_done, second_done);
    end
    checks++;
    if (pass_count !== 8'h02) begin
      errors++;
      $display("[TB] FAIL b2b_pass_count: got %h required 02", pass_count);
    end
  endtask

  task automatic test_mismatch_hunt();
    do_reset();
    drive(1'b1, 8'hAF, 1'b0);
    drive(1'b1, 8'hBC, 1'b0);
    drive(1'b1, 8'h55, 1'b0);
    checks++;
    if ({locked, mismatch} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL hunt_after_55: got locked,mismatch=%b required 01", {locked, mismatch});
    end
    drive(1'b1, 8'hBC, 1'b0);
    checks++;
    if ({locked, mismatch} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL hunt_ignores_bc: got locked,mismatch=%b required 00", {locked, mismatch});
    end
    checks++;
    if (err_count !== 8'h01) begin
      errors++;
      $display("[TB] FAIL hunt_err_count: got %h required 01", err_count);
    end
  endtask

  task automatic test_resync();
    logic [7:0] words [5] = '{8'hAF, 8'hBC, 8'hAF, 8'hBC, 8'hE2};
    logic [1:0] exp   [5] = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b10};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, words[i], 1'b0);
      checks++;
      if ({locked, mismatch} !== exp[i]) begin
        errors++;
        $display("[TB] FAIL resync_word%0d: got locked,mismatch=%b required %b", i,
                 {locked, mismatch}, exp[i]);
      end
    end
    checks++;
    if (err_count !== 8'h01) begin
      errors++;
      $display("[TB] FAIL resync_err_count: got %h required 01", err_count);
    end
  endtask

  task automatic test_en_gap();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, seq_words[i], 1'b0);
    for (int g = 0; g < 3; g++) begin
      drive(1'b0, 8'h00, 1'b0);
      checks++;
      if ({locked, seq_done, mismatch} !== 3'b100) begin
        errors++;
        $display("[TB] FAIL gap_cycle%0d: got %b required 100", g, {locked, seq_done, mismatch});
      end
    end
    for (int i = 4; i < 8; i++) drive(1'b1, seq_words[i], 1'b0);
    checks++;
    if ({seq_done, mismatch} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL gap_done: got done,mismatch=%b required 10", {seq_done, mismatch});
    end
    checks++;
    if (pass_count !== 8'h01 || err_count !== 8'h00) begin
      errors++;
      $display("[TB] FAIL gap_counts: got pass=%h err=%h required 01/00", pass_count, err_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (254) for (int i = 0; i < 8; i++) drive(1'b1, seq_words[i], 1'b0);
    checks++;
    if (pass_count !== 8'hFE) begin
      errors++;
      $display("[TB] FAIL sat_fe: got %h required FE", pass_count);
    end
    for (int i = 0; i < 8; i++) drive(1'b1, seq_words[i], 1'b0);
    checks++;
    if (pass_count !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL sat_ff: got %h required FF", pass_count);
    end
    for (int i = 0; i < 8; i++) drive(1'b1, seq_words[i], 1'b0);
    checks++;
    if (pass_count !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL sat_hold: got %h required FF", pass_count);
    end
    for (int i = 0; i < 7; i++) drive(1'b1, seq_words[i], 1'b0);
    drive(1'b1, 8'h8D, 1'b1);
    checks++;
    if ({locked, seq_done} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL clr_fsm_untouched: got locked,done=%b required 11", {locked, seq_done});
    end
    checks++;
    if (pass_count !== 8'h00) begin
      errors++;
      $display("[TB] FAIL clr_priority: got %h required 00", pass_count);
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset_midseq();
    do_reset();
    drive(1'b1, 8'hAF, 1'b0);
    drive(1'b1, 8'hBC, 1'b0);
    drive(1'b1, 8'hE2, 1'b0);
    #2;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset_locked: got %b required 0", locked);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'hBC, 1'b0);
    checks++;
    if ({locked, mismatch} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL post_reset_bc: got locked,mismatch=%b required 00", {locked, mismatch});
    end
    drive(1'b1, 8'hAF, 1'b0);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_relock: got %b required 1", locked);
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_back_to_back();
    test_mismatch_hunt();
    test_resync();
    test_en_gap();
    test_saturation();
    test_reset_midseq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
